mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single byte-wide synchronous RAM port between instruction fetch (IF) and the memory stage (MEM) of the pipeline. Each request is split into sequential byte accesses: 4 bytes for IF, and 1/2/4 bytes for MEM. The bytes are assembled little-endian, and completion is signalled with a one-cycle done pulse. The IF and MEM stage registers use the done pulses as their advance/stall condition.

## Interface
- ADDR_W, 17: RAM address width; byte addresses are truncated to ADDR_W bits.

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  IF fetch request, level, held until if_done
- if_addr  in  32  IF byte address
- if_data  out  32  fetched word, valid with if_done, held until next if_done
- if_done  out  1  one-cycle completion pulse
- mem_req  in  1  MEM request, level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  MEM byte address
- mem_len  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_wdata  in  32  store data, little-endian
- mem_rdata  out  32  load data, zero-extended, valid with mem_done, held until next load done
- mem_done  out  1  one-cycle completion pulse
- ram_a  out  ADDR_W  RAM byte address, registered
- ram_we  out  1  RAM write enable, registered
- ram_dout  out  8  RAM write byte, registered
- ram_din  in  8  RAM read byte, valid the cycle after its address
- busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, RD_IF, RD_MEM, WR_MEM. Byte counter cnt (0..3). Byte count n = 4 for IF; for MEM, n = 1/2/4 per mem_len.
- Grant in IDLE:
  - Only one request asserted: that requester is granted.
  - Both asserted: grant goes to the requester not granted last (last_grant register).
  - last_grant resets to IF, so the first tie grants MEM.
- Transfers are non-preemptive. A granted transaction always completes.
- Address and data per byte:
  - Byte i is at address (addr + i) mod 2^ADDR_W; wrap-around is allowed.
  - Byte i maps to data bits [8i+7:8i].
  - Load bits above 8n are 0. Sign extension is done by the MEM stage.
- Request inputs (addr, len, we, wdata) are latched at grant. Later changes are ignored until done.
- Requester dropping req mid-transaction: illegal. The arbiter completes the transaction and still pulses done.
- After done, the FSM is in IDLE for at least one cycle before the next grant. A requester sees done at the clock edge and drops req, so no duplicate grant occurs.
- Reset values: if_data, mem_rdata, if_done, mem_done, ram_a, ram_we, ram_dout and busy are all 0. State = IDLE, cnt = 0, last_grant = IF.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately (asynchronously) and ram_we drops at once.
  - No done pulse is issued and partial data is discarded.

## Timing
Cycle 0 is the IDLE cycle in which the granted request is sampled.
- Read of n bytes:
  - ram_a = addr+i and ram_we = 0 in cycles 1..n.
  - ram_din for byte i is captured in cycle i+2.
  - done pulses in cycle n+2 with data valid.
  - Word read (IF or MEM): done in cycle 6. Byte read: done in cycle 3.
- Write of n bytes:
  - ram_a = addr+i, ram_we = 1 and ram_dout = byte i in cycles 1..n.
  - done pulses in cycle n+1. Word write: done in cycle 5.
- busy is high from cycle 1 through the done cycle, and low in IDLE.
- ram_a, ram_we and ram_dout are 0 in IDLE cycles.
- Back-to-back transactions: done in cycle D, IDLE in cycle D+1, next transfer starts in cycle D+2.
- Maximum IF wait while MEM is pending: one MEM transaction plus one IDLE cycle.

## Test plan
- Reset, then IF word read at 0x100. RAM[0x100..0x103] = 11 22 33 44 -> if_data = 0x44332211 with if_done in cycle 6; ram_we stays 0 throughout.
- MEM byte store of 0xAB at 0x205, then half load at 0x204 -> store: ram_we for one cycle at 0x205, mem_done in cycle 2. Load: mem_rdata = 0x0000AB00 (byte at 0x204 = 00), mem_done in cycle 4.
- if_req and mem_req both high from reset -> MEM granted first. IF granted next (alternation), even though mem_req was re-raised before IF's grant.
- Word load at 2^ADDR_W − 2 -> bytes read from addresses 0x1FFFE, 0x1FFFF, 0x0, 0x1, assembled correctly.
- Reset pulsed low in cycle 3 of a word write -> ram_we = 0 immediately, no mem_done, busy = 0. A fresh request after reset completes normally.
- Request held across done for one cycle -> exactly one done pulse per transaction. The second transaction starts only when req is re-asserted in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between the
// instruction-fetch and memory stages, splitting each request into
// sequential byte accesses and assembling the result little-endian.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_MEM, WR_MEM} state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    state_t            state, state_next;
    logic [2:0]        step, step_next;
    logic [2:0]        n_bytes, n_next;
    logic              last_grant, lg_next;
    logic [ADDR_W-1:0] lat_addr, addr_next;
    logic [31:0]       lat_wdata, wdata_next;
    logic [31:0]       asm_buf, asm_next;
    logic [31:0]       if_data_next, mem_rdata_next;
    logic              if_done_next, mem_done_next;
    logic [ADDR_W-1:0] ram_a_next;
    logic              ram_we_next;
    logic [7:0]        ram_dout_next;

    logic [2:0]        step_inc;
    logic [2:0]        rd_idx;
    logic [31:0]       merged;
    logic              grant_mem;
    logic              grant_if;

    // Upper address bits are dropped: the RAM only decodes ADDR_W bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    assign busy = (state != IDLE);

    // State register; reset drops any transfer in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Datapath and registered RAM/handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step       <= '0;
            n_bytes    <= '0;
            last_grant <= GRANT_IF;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            asm_buf    <= '0;
            if_data    <= '0;
            mem_rdata  <= '0;
            if_done    <= 1'b0;
            mem_done   <= 1'b0;
            ram_a      <= '0;
            ram_we     <= 1'b0;
            ram_dout   <= '0;
        end else begin
            step       <= step_next;
            n_bytes    <= n_next;
            last_grant <= lg_next;
            lat_addr   <= addr_next;
            lat_wdata  <= wdata_next;
            asm_buf    <= asm_next;
            if_data    <= if_data_next;
            mem_rdata  <= mem_rdata_next;
            if_done    <= if_done_next;
            mem_done   <= mem_done_next;
            ram_a      <= ram_a_next;
            ram_we     <= ram_we_next;
            ram_dout   <= ram_dout_next;
        end
    end

    // Grant arbitration, byte sequencing and read-data assembly. step counts
    // cycles since grant (step = k-1 in cycle k); the RAM outputs for the
    // following cycle are computed here so they leave the chip registered.
    always_comb begin
        state_next     = state;
        step_next      = step;
        n_next         = n_bytes;
        lg_next        = last_grant;
        addr_next      = lat_addr;
        wdata_next     = lat_wdata;
        asm_next       = asm_buf;
        if_data_next   = if_data;
        mem_rdata_next = mem_rdata;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        ram_a_next     = '0;
        ram_we_next    = 1'b0;
        ram_dout_next  = '0;

        step_inc  = step + 3'd1;
        rd_idx    = step - 3'd1;
        merged    = asm_buf;
        merged[8*rd_idx[1:0] +: 8] = ram_din;
        grant_mem = mem_req && (!if_req || last_grant == GRANT_IF);
        grant_if  = if_req && !grant_mem;

        case (state)
            IDLE: begin
                step_next = '0;
                asm_next  = '0;
                if (grant_mem) begin
                    state_next    = mem_we ? WR_MEM : RD_MEM;
                    lg_next       = GRANT_MEM;
                    addr_next     = mem_addr[ADDR_W-1:0];
                    wdata_next    = mem_wdata;
                    ram_a_next    = mem_addr[ADDR_W-1:0];
                    ram_we_next   = mem_we;
                    ram_dout_next = mem_we ? mem_wdata[7:0] : 8'h00;
                    case (mem_len)
                        2'b00:   n_next = 3'd1;
                        2'b01:   n_next = 3'd2;
                        default: n_next = 3'd4;
                    endcase
                end else if (grant_if) begin
                    state_next = RD_IF;
                    lg_next    = GRANT_IF;
                    addr_next  = if_addr[ADDR_W-1:0];
                    n_next     = 3'd4;
                    ram_a_next = if_addr[ADDR_W-1:0];
                end
            end
            default: begin
                if (if_done || mem_done) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else begin
                    step_next = step_inc;
                    if (step_inc < n_bytes) begin
                        ram_a_next    = lat_addr + ADDR_W'(step_inc);
                        ram_we_next   = (state == WR_MEM);
                        ram_dout_next = (state == WR_MEM) ? lat_wdata[8*step_inc[1:0] +: 8] : 8'h00;
                    end
                    if (state == WR_MEM) begin
                        mem_done_next = (step == n_bytes - 3'd1);
                    end else if (step != 3'd0 && rd_idx < n_bytes) begin
                        asm_next = merged;
                        if (step == n_bytes) begin
                            if (state == RD_IF) begin
                                if_data_next = merged;
                                if_done_next = 1'b1;
                            end else begin
                                mem_rdata_next = merged;
                                mem_done_next  = 1'b1;
                            end
                        end
                    end
                end
            end
        endcase
    end

endmodule
